// File: rtl/mips_rf_wb_arbiter.sv
// Register-file write-port controller: zero-initialises every writable register after reset,
// then round-robin arbitrates NREQ writeback requesters onto the single write port.
module mips_rf_wb_arbiter #(
    parameter int unsigned AWL  = 5,
    parameter int unsigned DWL  = 32,
    parameter int unsigned NREQ = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                soft_init,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*AWL-1:0] req_addr,
    input  logic [NREQ*DWL-1:0] req_data,
    output logic [NREQ-1:0]     req_ready,
    output logic                rf_wen,
    output logic [AWL-1:0]      rf_wa,
    output logic [DWL-1:0]      rf_wd,
    output logic                init_done,
    output logic                zero_drop
);
    localparam int unsigned PW = $clog2(NREQ);

    typedef enum logic {StInit, StRun} state_e;

    state_e         state_q, state_d;
    logic [AWL-1:0] cnt_q, cnt_d;
    logic [PW-1:0]  rr_q, rr_d;
    logic           wen_q, wen_d;
    logic [AWL-1:0] wa_q, wa_d;
    logic [DWL-1:0] wd_q, wd_d;
    logic           done_q, done_d;
    logic           zd_q, zd_d;

    logic           found;
    logic           xfer;
    logic [PW-1:0]  gnt_idx;
    logic [PW-1:0]  idx;
    logic [AWL-1:0] sel_addr;
    logic [DWL-1:0] sel_data;

    // Round-robin scan starting at rr_q; first valid requester wins.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = PW'((32'(rr_q) + k) % NREQ);
            if (!found && req_valid[idx]) begin
                found   = 1'b1;
                gnt_idx = idx;
            end
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_idx == PW'(i)) begin
                sel_addr = req_addr[i*AWL +: AWL];
                sel_data = req_data[i*DWL +: DWL];
            end
        end
    end

    assign xfer      = (state_q == StRun) && !soft_init && found;
    assign req_ready = xfer ? (NREQ'(1) << gnt_idx) : '0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        wen_d   = 1'b0;
        wa_d    = wa_q;
        wd_d    = wd_q;
        done_d  = done_q;
        zd_d    = 1'b0;
        if (soft_init) begin
            // Restart the sweep; rr_q is kept so fairness survives a re-init.
            state_d = StInit;
            cnt_d   = AWL'(1);
            done_d  = 1'b0;
        end else if (state_q == StInit) begin
            wen_d = 1'b1;
            wa_d  = cnt_q;
            wd_d  = '0;
            cnt_d = cnt_q + AWL'(1);
            if (cnt_q == '1) begin
                state_d = StRun;
                done_d  = 1'b1;
            end
        end else if (xfer) begin
            wa_d = sel_addr;
            wd_d = sel_data;
            rr_d = (32'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + PW'(1);
            // Writes to $zero are accepted but never reach the register file.
            if (sel_addr != '0) begin
                wen_d = 1'b1;
            end else begin
                zd_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StInit;
            cnt_q   <= AWL'(1);
            rr_q    <= '0;
            wen_q   <= 1'b0;
            wa_q    <= '0;
            wd_q    <= '0;
            done_q  <= 1'b0;
            zd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            wen_q   <= wen_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
            done_q  <= done_d;
            zd_q    <= zd_d;
        end
    end

    assign rf_wen    = wen_q;
    assign rf_wa     = wa_q;
    assign rf_wd     = wd_q;
    assign init_done = done_q;
    assign zero_drop = zd_q;

endmodule

// File: tb/tb_mips_rf_wb_arbiter.sv
// Directed bench for mips_rf_wb_arbiter: sweep, arbitration table, zero drop, soft re-init and
// asynchronous reset mid-sweep.
module tb_mips_rf_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        soft_init;
    logic [2:0]  req_valid;
    logic [14:0] req_addr;
    logic [95:0] req_data;
    logic [2:0]  req_ready;
    logic        rf_wen;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic        init_done;
    logic        zero_drop;

    int n_cmp = 0;
    int n_err = 0;

    mips_rf_wb_arbiter #(.AWL(5), .DWL(32), .NREQ(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .soft_init (soft_init),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rf_wen    (rf_wen),
        .rf_wa     (rf_wa),
        .rf_wd     (rf_wd),
        .init_done (init_done),
        .zero_drop (zero_drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  valid;
        logic [4:0]  a0, a1, a2;
        logic [31:0] d0, d1, d2;
        logic [2:0]  rdy;
        logic        wen;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        zd;
    } vec_t;

    vec_t tbl[15];

    function automatic vec_t mk(logic [2:0] v, logic [4:0] a0, logic [4:0] a1, logic [4:0] a2,
                                logic [31:0] d0, logic [31:0] d1, logic [31:0] d2,
                                logic [2:0] rdy, logic wen, logic [4:0] wa, logic [31:0] wd,
                                logic zd);
        vec_t r;
        r.valid = v;
        r.a0 = a0; r.a1 = a1; r.a2 = a2;
        r.d0 = d0; r.d1 = d1; r.d2 = d2;
        r.rdy = rdy; r.wen = wen; r.wa = wa; r.wd = wd; r.zd = zd;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic wen, input logic [4:0] wa,
                           input logic [31:0] wd, input logic done, input logic zd);
        chk({tag, ".rf_wen"}, 32'(rf_wen), 32'(wen));
        chk({tag, ".rf_wa"}, 32'(rf_wa), 32'(wa));
        chk({tag, ".rf_wd"}, rf_wd, wd);
        chk({tag, ".init_done"}, 32'(init_done), 32'(done));
        chk({tag, ".zero_drop"}, 32'(zero_drop), 32'(zd));
    endtask

    initial begin
        tbl[0]  = mk(3'b010, 0, 7, 0, 0, 32'hDEADBEEF, 0, 3'b010, 1, 7, 32'hDEADBEEF, 0);
        tbl[1]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0, 7, 32'hDEADBEEF, 0);
        tbl[2]  = mk(3'b100, 0, 0, 3, 0, 0, 32'h33, 3'b100, 1, 3, 32'h33, 0);
        tbl[3]  = mk(3'b111, 10, 11, 12, 32'hA0, 32'hB1, 32'hC2, 3'b001, 1, 10, 32'hA0, 0);
        tbl[4]  = mk(3'b111, 10, 11, 12, 32'hA0, 32'hB1, 32'hC2, 3'b010, 1, 11, 32'hB1, 0);
        tbl[5]  = mk(3'b111, 10, 11, 12, 32'hA0, 32'hB1, 32'hC2, 3'b100, 1, 12, 32'hC2, 0);
        tbl[6]  = mk(3'b111, 10, 11, 12, 32'hA0, 32'hB1, 32'hC2, 3'b001, 1, 10, 32'hA0, 0);
        tbl[7]  = mk(3'b111, 10, 11, 12, 32'hA0, 32'hB1, 32'hC2, 3'b010, 1, 11, 32'hB1, 0);
        tbl[8]  = mk(3'b111, 10, 11, 12, 32'hA0, 32'hB1, 32'hC2, 3'b100, 1, 12, 32'hC2, 0);
        tbl[9]  = mk(3'b001, 0, 0, 0, 32'h1234, 0, 0, 3'b001, 0, 0, 32'h1234, 1);
        tbl[10] = mk(3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 32'h1234, 0);
        tbl[11] = mk(3'b101, 21, 0, 20, 32'h2100, 0, 32'h2000, 3'b100, 1, 20, 32'h2000, 0);
        tbl[12] = mk(3'b001, 21, 0, 0, 32'h2100, 0, 0, 3'b001, 1, 21, 32'h2100, 0);
        tbl[13] = mk(3'b011, 6, 5, 0, 32'h66, 32'h55, 0, 3'b010, 1, 5, 32'h55, 0);
        tbl[14] = mk(3'b001, 6, 0, 0, 32'h66, 0, 0, 3'b001, 1, 6, 32'h66, 0);

        rst_n     = 1'b1;
        soft_init = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        #1 rst_n = 1'b0;
        #2;
        chk_out("reset", 0, 0, 0, 0, 0);
        chk("reset.req_ready", 32'(req_ready), 0);
        repeat (2) step();
        rst_n = 1'b1;

        // Initial sweep: addresses 1..31, done on the last write.
        for (int k = 1; k <= 31; k++) begin
            step();
            chk_out($sformatf("sweep%0d", k), 1, 5'(k), 0, (k == 31), 0);
        end
        step();
        chk_out("post_sweep", 0, 31, 0, 1, 0);

        for (int r = 0; r < 15; r++) begin
            req_valid = tbl[r].valid;
            req_addr  = {tbl[r].a2, tbl[r].a1, tbl[r].a0};
            req_data  = {tbl[r].d2, tbl[r].d1, tbl[r].d0};
            #1;
            chk($sformatf("row%0d.req_ready", r), 32'(req_ready), 32'(tbl[r].rdy));
            step();
            chk_out($sformatf("row%0d", r), tbl[r].wen, tbl[r].wa, tbl[r].wd, 1, tbl[r].zd);
        end

        // Soft init while requester 2 waits; rr pointer is 1 here so it would otherwise win.
        soft_init = 1'b1;
        req_valid = 3'b100;
        req_addr  = {5'd9, 5'd0, 5'd0};
        req_data  = {32'h99, 32'h0, 32'h0};
        #1;
        chk("soft.req_ready", 32'(req_ready), 0);
        step();
        soft_init = 1'b0;
        chk_out("soft.edge", 0, 6, 32'h66, 0, 0);
        for (int k = 1; k <= 31; k++) begin
            chk($sformatf("soft_sweep%0d.req_ready", k), 32'(req_ready), 0);
            step();
            chk_out($sformatf("soft_sweep%0d", k), 1, 5'(k), 0, (k == 31), 0);
        end
        chk("soft.final.req_ready", 32'(req_ready), 32'(3'b100));
        step();
        req_valid = '0;
        chk_out("soft.accept", 1, 9, 32'h99, 1, 0);

        // Asynchronous reset in the middle of a sweep.
        soft_init = 1'b1;
        step();
        soft_init = 1'b0;
        for (int k = 1; k <= 12; k++) step();
        chk("mid.rf_wa_12", 32'(rf_wa), 12);
        rst_n = 1'b0;
        #1;
        chk_out("mid_reset", 0, 0, 0, 0, 0);
        step();
        chk_out("mid_reset_hold", 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk_out($sformatf("restart%0d", k), 1, 5'(k), 0, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mips_rf_wb_arbiter.md
# mips_rf_wb_arbiter

Write-port controller for the MIPS register file. After reset it sequences a zero-initialisation sweep of every writable register, then shares the register file's single write port among NREQ writeback requesters (e.g. ALU, load, multiply/divide) using round-robin arbitration and a valid/ready handshake. Its registered outputs drive the register file's write enable, write address and write data directly.

## Interface
- AWL, 5, register address width; must match the register file.
- DWL, 32, register data width; must match the register file.
- NREQ, 3, number of writeback requesters; legal range 2..8.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- soft_init  in  1  synchronous request to restart the zero sweep.
- req_valid  in  NREQ  per-requester write request.
- req_addr  in  NREQ*AWL  destination register; requester i occupies bits [i*AWL +: AWL].
- req_data  in  NREQ*DWL  write data; requester i occupies bits [i*DWL +: DWL].
- req_ready  out  NREQ  one-hot grant; combinational.
- rf_wen  out  1  register file write enable; registered.
- rf_wa  out  AWL  register file write address; registered.
- rf_wd  out  DWL  register file write data; registered.
- init_done  out  1  high when the block is in RUN and accepting requests.
- zero_drop  out  1  one-cycle pulse when an accepted write to register 0 is discarded.

## Operation
- Two states: INIT (zero sweep) and RUN (arbitration).
- Reset: state = INIT, sweep counter cnt = 1, rr_ptr = 0.
- Reset values of registered outputs: rf_wen = 0, rf_wa = 0, rf_wd = 0, init_done = 0, zero_drop = 0.
- INIT, on each edge:
  - rf_wen <= 1, rf_wa <= cnt, rf_wd <= 0.
  - cnt <= cnt + 1, using an AWL-bit counter.
  - When cnt == 2**AWL-1: state <= RUN and init_done <= 1 on the same edge.
  - Register 0 is never written by the sweep.
- req_ready is all-zero whenever state is INIT or soft_init = 1.
- RUN, arbitration:
  - Scan requesters starting at rr_ptr, wrapping modulo NREQ.
  - The first i with req_valid[i] = 1 gets req_ready[i] = 1; all other ready bits are 0.
  - A transfer occurs when req_valid[i] and req_ready[i] are both high at an edge.
- On a transfer:
  - rf_wa <= req_addr[i], rf_wd <= req_data[i].
  - rr_ptr <= (i+1) mod NREQ.
  - If req_addr[i] != 0: rf_wen <= 1.
  - If req_addr[i] == 0: rf_wen <= 0 and zero_drop <= 1. The request still completes; the requester sees it accepted.
- With no transfer in RUN: rf_wen <= 0, zero_drop <= 0, and rr_ptr, rf_wa and rf_wd hold.
- Requester rules: once req_valid is asserted, it stays high with addr and data stable until accepted. req_valid must not depend combinationally on req_ready.
- soft_init = 1 at an edge, in either state: state <= INIT, cnt <= 1, init_done <= 0, rf_wen <= 0. No transfer occurs in that cycle. rr_ptr is preserved. Pending requests wait.

## Timing
- The sweep occupies 2**AWL-1 consecutive write cycles (31 for AWL = 5).
- rf_wen first rises at the first edge after rst_n deasserts.
- init_done rises on the same edge as the last sweep write (address 2**AWL-1). The first request can be accepted in that cycle, so no idle gap exists.
- Acceptance at edge k puts rf_wen/rf_wa/rf_wd on the port in cycle k..k+1. The register file captures the write at edge k+1.
- Throughput: one write per cycle, sustained.
- Fairness: with all NREQ requesters continuously valid, each is granted exactly once every NREQ cycles.
- rst_n asserted at any point, including mid-sweep or mid-transfer, immediately forces the reset values. The sweep then restarts from address 1.

## Test plan
- Reset release, no requests -> rf_wen high for 31 cycles with rf_wa = 1..31 and rf_wd = 0; init_done rises on the edge writing address 31; rf_wen = 0 afterwards.
- After init, requester 1 writes addr 7, data 0xDEADBEEF -> req_ready = 3'b010 in that cycle; next cycle rf_wen = 1, rf_wa = 7, rf_wd = 0xDEADBEEF; rr_ptr = 2.
- All three requesters held valid from rr_ptr = 0 -> grants in order 0, 1, 2, 0, 1, 2; one rf_wen pulse per cycle with matching addr/data.
- Requester 0 writes addr 0, data 0x1234 -> accepted; next cycle rf_wen = 0 and zero_drop = 1 for exactly one cycle.
- soft_init pulsed in RUN while requester 2 is valid -> req_ready = 0 in that cycle; init_done falls; a full 31-cycle sweep runs; requester 2 is accepted on the sweep's final cycle.
- rst_n asserted at sweep address 12 -> all outputs reach reset values immediately; after release the sweep restarts at address 1.
